// File: rtl/regs_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the core
// writeback stage (requester 0) and the debug/loader port (requester 1).
`timescale 1ns/1ps

module regs_write_arbiter #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          stall,
  input  logic          reqV0,
  input  logic          reqV1,
  input  logic [AW-1:0] reqReg0,
  input  logic [AW-1:0] reqReg1,
  input  logic          reqIsReg0,
  input  logic          reqIsReg1,
  input  logic [DW-1:0] reqData0,
  input  logic [DW-1:0] reqData1,
  input  logic          reqWData0,
  input  logic          reqWData1,
  input  logic          reqFlipEn0,
  input  logic          reqFlipEn1,
  input  logic          reqFlip0,
  input  logic          reqFlip1,
  input  logic          reqFlagEn0,
  input  logic          reqFlagEn1,
  input  logic          reqFlag0,
  input  logic          reqFlag1,
  output logic          ready0,
  output logic          ready1,
  output logic          isWrite,
  output logic [AW-1:0] writeReg,
  output logic          isRegW,
  output logic [DW-1:0] writeData,
  output logic          writeFlip,
  output logic          flipin,
  output logic          writeFlag,
  output logic          flagin,
  output logic          grantId,
  output logic          busy
);

  typedef struct packed {
    logic [AW-1:0] rg;
    logic          is_reg;
    logic [DW-1:0] data;
    logic          wdata;
    logic          flip_en;
    logic          flip;
    logic          flag_en;
    logic          flag;
  } slot_t;

  slot_t       slot [2];
  slot_t       req  [2];
  slot_t       sel;
  logic [1:0]  full;
  logic [1:0]  ready;
  logic [1:0]  accept;
  logic [1:0]  grant;
  logic        gnt_v;
  logic        gnt_id;
  logic        last;

  assign req[0] = '{rg: reqReg0, is_reg: reqIsReg0, data: reqData0, wdata: reqWData0,
                    flip_en: reqFlipEn0, flip: reqFlip0, flag_en: reqFlagEn0, flag: reqFlag0};
  assign req[1] = '{rg: reqReg1, is_reg: reqIsReg1, data: reqData1, wdata: reqWData1,
                    flip_en: reqFlipEn1, flip: reqFlip1, flag_en: reqFlagEn1, flag: reqFlag1};

  // NOTE: every output of an always_comb is defaulted first so no path infers a latch.
  always_comb begin
    gnt_v  = 1'b0;
    gnt_id = 1'b0;
    if (!stall) begin
      if (&full) begin
        gnt_v  = 1'b1;
        gnt_id = ~last;
      end else if (full[0]) begin
        gnt_v  = 1'b1;
        gnt_id = 1'b0;
      end else if (full[1]) begin
        gnt_v  = 1'b1;
        gnt_id = 1'b1;
      end
    end
  end

  // A slot granted this cycle frees up on the same edge, so it can be refilled.
  assign grant  = {gnt_v & gnt_id, gnt_v & ~gnt_id};
  assign ready  = ~full | grant;
  assign accept = {reqV1, reqV0} & ready;
  assign sel    = slot[gnt_id];

  assign ready0 = ready[0];
  assign ready1 = ready[1];
  assign busy   = |full;

  // NOTE: slot payloads carry no reset; the full bits alone say whether they hold anything.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      if (accept[i]) slot[i] <= req[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      full <= 2'b00;
      last <= 1'b1;
    end else begin
      full <= accept | (full & ~grant);
      if (gnt_v) last <= gnt_id;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      isWrite   <= 1'b0;
      writeFlip <= 1'b0;
      writeFlag <= 1'b0;
      writeReg  <= '0;
      isRegW    <= 1'b0;
      writeData <= '0;
      flipin    <= 1'b0;
      flagin    <= 1'b0;
      grantId   <= 1'b0;
    end else if (gnt_v) begin
      isWrite   <= sel.wdata;
      writeFlip <= sel.flip_en;
      writeFlag <= sel.flag_en;
      writeReg  <= sel.rg;
      isRegW    <= sel.is_reg;
      writeData <= sel.data;
      flipin    <= sel.flip;
      flagin    <= sel.flag;
      grantId   <= gnt_id;
    end else begin
      // Idle edge: drop the enables, keep the last bundle visible.
      isWrite   <= 1'b0;
      writeFlip <= 1'b0;
      writeFlag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regs_write_arbiter.sv
// Self-checking bench for regs_write_arbiter: queue-based reference model,
// per-cycle output comparison, directed scenarios and a randomized phase.
`timescale 1ns/1ps

module tb_regs_write_arbiter;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       stall = 1'b0;
  logic       reqV0 = 1'b0, reqV1 = 1'b0;
  logic [2:0] reqReg0 = '0, reqReg1 = '0;
  logic       reqIsReg0 = 1'b0, reqIsReg1 = 1'b0;
  logic [7:0] reqData0 = '0, reqData1 = '0;
  logic       reqWData0 = 1'b0, reqWData1 = 1'b0;
  logic       reqFlipEn0 = 1'b0, reqFlipEn1 = 1'b0, reqFlip0 = 1'b0, reqFlip1 = 1'b0;
  logic       reqFlagEn0 = 1'b0, reqFlagEn1 = 1'b0, reqFlag0 = 1'b0, reqFlag1 = 1'b0;
  logic       ready0, ready1, isWrite, isRegW, writeFlip, flipin, writeFlag, flagin;
  logic       grantId, busy;
  logic [2:0] writeReg;
  logic [7:0] writeData;

  regs_write_arbiter #(.DW(8), .AW(3)) dut (
    .CLK(CLK), .RST_N(RST_N), .stall(stall),
    .reqV0(reqV0), .reqV1(reqV1),
    .reqReg0(reqReg0), .reqReg1(reqReg1),
    .reqIsReg0(reqIsReg0), .reqIsReg1(reqIsReg1),
    .reqData0(reqData0), .reqData1(reqData1),
    .reqWData0(reqWData0), .reqWData1(reqWData1),
    .reqFlipEn0(reqFlipEn0), .reqFlipEn1(reqFlipEn1),
    .reqFlip0(reqFlip0), .reqFlip1(reqFlip1),
    .reqFlagEn0(reqFlagEn0), .reqFlagEn1(reqFlagEn1),
    .reqFlag0(reqFlag0), .reqFlag1(reqFlag1),
    .ready0(ready0), .ready1(ready1),
    .isWrite(isWrite), .writeReg(writeReg), .isRegW(isRegW), .writeData(writeData),
    .writeFlip(writeFlip), .flipin(flipin), .writeFlag(writeFlag), .flagin(flagin),
    .grantId(grantId), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0] rg;
    logic       is_reg;
    logic [7:0] data;
    logic       wdata;
    logic       flip_en;
    logic       flip;
    logic       flag_en;
    logic       flag;
  } req_t;

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  req_t q0[$];
  req_t q1[$];
  bit   m_last = 1'b1;
  req_t m_out = '0;
  bit   m_grant = 1'b0;
  bit   m_we = 1'b0, m_wflip = 1'b0, m_wflag = 1'b0;

  function automatic void model_grant(output bit gv, output bit gi);
    gv = 1'b0;
    gi = 1'b0;
    if (!stall) begin
      if (q0.size() != 0 && q1.size() != 0) begin
        gv = 1'b1;
        gi = !m_last;
      end else if (q0.size() != 0) begin
        gv = 1'b1;
      end else if (q1.size() != 0) begin
        gv = 1'b1;
        gi = 1'b1;
      end
    end
  endfunction

  function automatic bit m_ready(input bit i);
    bit gv, gi, empty;
    model_grant(gv, gi);
    empty = i ? (q1.size() == 0) : (q0.size() == 0);
    return empty || (gv && gi == i);
  endfunction

  function automatic req_t in_req(input bit i);
    if (i) return '{reqReg1, reqIsReg1, reqData1, reqWData1, reqFlipEn1, reqFlip1, reqFlagEn1, reqFlag1};
    return '{reqReg0, reqIsReg0, reqData0, reqWData0, reqFlipEn0, reqFlip0, reqFlagEn0, reqFlag0};
  endfunction

  bit   mg_v, mg_i, mr0, mr1;
  req_t mg_req;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q0.delete();
      q1.delete();
      m_last  = 1'b1;
      m_out   = '0;
      m_grant = 1'b0;
      m_we    = 1'b0;
      m_wflip = 1'b0;
      m_wflag = 1'b0;
    end else begin
      model_grant(mg_v, mg_i);
      mr0 = m_ready(1'b0);
      mr1 = m_ready(1'b1);
      if (mg_v) begin
        if (mg_i) mg_req = q1.pop_front();
        else      mg_req = q0.pop_front();
        m_out   = mg_req;
        m_grant = mg_i;
        m_last  = mg_i;
        m_we    = mg_req.wdata;
        m_wflip = mg_req.flip_en;
        m_wflag = mg_req.flag_en;
      end else begin
        m_we    = 1'b0;
        m_wflip = 1'b0;
        m_wflag = 1'b0;
      end
      if (reqV0 && mr0) q0.push_back(in_req(1'b0));
      if (reqV1 && mr1) q1.push_back(in_req(1'b1));
    end
  end

  // Every cycle, mid-period, the DUT must agree with the model.
  always @(negedge CLK) begin
    if (cmp_en) begin
      check("isWrite",   32'(isWrite),   32'(m_we));
      check("writeFlip", 32'(writeFlip), 32'(m_wflip));
      check("writeFlag", 32'(writeFlag), 32'(m_wflag));
      check("writeReg",  32'(writeReg),  32'(m_out.rg));
      check("isRegW",    32'(isRegW),    32'(m_out.is_reg));
      check("writeData", 32'(writeData), 32'(m_out.data));
      check("flipin",    32'(flipin),    32'(m_out.flip));
      check("flagin",    32'(flagin),    32'(m_out.flag));
      check("grantId",   32'(grantId),   32'(m_grant));
      check("busy",      32'(busy),      32'(q0.size() != 0 || q1.size() != 0));
      check("ready0",    32'(ready0),    32'(m_ready(1'b0)));
      check("ready1",    32'(ready1),    32'(m_ready(1'b1)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic set_req(input bit i, input req_t r);
    if (i) begin
      {reqReg1, reqIsReg1, reqData1, reqWData1, reqFlipEn1, reqFlip1, reqFlagEn1, reqFlag1} = r;
    end else begin
      {reqReg0, reqIsReg0, reqData0, reqWData0, reqFlipEn0, reqFlip0, reqFlagEn0, reqFlag0} = r;
    end
  endtask

  function automatic req_t rand_req();
    req_t r;
    r = req_t'($urandom);
    return r;
  endfunction

  task automatic do_reset();
    RST_N = 1'b0;
    reqV0 = 1'b0;
    reqV1 = 1'b0;
    stall = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    RST_N = 1'b1;
  endtask

  req_t r;
  bit   acc0, acc1, pend0, pend1;
  int   a0, a1;

  initial begin
    do_reset();
    cmp_en = 1'b1;
    #1;
    check("rst_isWrite", 32'(isWrite), 32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_ready0",  32'(ready0),  32'd1);
    check("rst_ready1",  32'(ready1),  32'd1);

    // Single write from requester 0.
    r = '{rg: 3'b010, is_reg: 1'b1, data: 8'hA5, wdata: 1'b1, default: '0};
    set_req(1'b0, r);
    reqV0 = 1'b1;
    tick();
    reqV0 = 1'b0;
    tick();
    check("t1_isWrite",   32'(isWrite),   32'd1);
    check("t1_writeReg",  32'(writeReg),  32'd2);
    check("t1_isRegW",    32'(isRegW),    32'd1);
    check("t1_writeData", 32'(writeData), 32'hA5);
    check("t1_grantId",   32'(grantId),   32'd0);
    tick();
    check("t1_isWrite_off", 32'(isWrite), 32'd0);
    check("t1_busy_off",    32'(busy),    32'd0);

    // Contention from reset: strictly alternating grants.
    do_reset();
    a0 = 0;
    a1 = 0;
    for (int k = 0; k < 7; k++) begin
      set_req(1'b0, '{rg: 3'd1, is_reg: 1'b1, data: 8'(8'h10 + a0), wdata: 1'b1, default: '0});
      set_req(1'b1, '{rg: 3'd1, is_reg: 1'b1, data: 8'(8'h20 + a1), wdata: 1'b1, default: '0});
      reqV0 = 1'b1;
      reqV1 = 1'b1;
      #1;
      acc0 = ready0;
      acc1 = ready1;
      tick();
      if (acc0) a0++;
      if (acc1) a1++;
      if (k == 0) begin
        check("rr_ready1_blocked", 32'(ready1), 32'd0);
        check("rr_ready0_free",    32'(ready0), 32'd1);
      end else begin
        check("rr_grantId", 32'(grantId), 32'((k - 1) % 2));
        check("rr_data", 32'(writeData),
              ((k - 1) % 2 == 0) ? 32'(8'h10 + (k - 1) / 2) : 32'(8'h20 + (k - 1) / 2));
        check("rr_isWrite", 32'(isWrite), 32'd1);
      end
    end
    reqV0 = 1'b0;
    reqV1 = 1'b0;
    repeat (3) tick();

    // Flip/flag-only request from requester 1.
    set_req(1'b1, '{rg: 3'd5, is_reg: 1'b0, data: 8'h3C, wdata: 1'b0,
                    flip_en: 1'b1, flip: 1'b1, flag_en: 1'b1, flag: 1'b0});
    reqV1 = 1'b1;
    tick();
    reqV1 = 1'b0;
    tick();
    check("ff_isWrite",   32'(isWrite),   32'd0);
    check("ff_writeFlip", 32'(writeFlip), 32'd1);
    check("ff_flipin",    32'(flipin),    32'd1);
    check("ff_writeFlag", 32'(writeFlag), 32'd1);
    check("ff_flagin",    32'(flagin),    32'd0);
    check("ff_grantId",   32'(grantId),   32'd1);
    tick();

    // Stall while both slots fill, then release.
    stall = 1'b1;
    set_req(1'b0, '{rg: 3'd3, is_reg: 1'b1, data: 8'h55, wdata: 1'b1, default: '0});
    set_req(1'b1, '{rg: 3'd4, is_reg: 1'b1, data: 8'hAA, wdata: 1'b1, default: '0});
    reqV0 = 1'b1;
    reqV1 = 1'b1;
    tick();
    reqV0 = 1'b0;
    reqV1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("st_ready0",  32'(ready0),  32'd0);
      check("st_ready1",  32'(ready1),  32'd0);
      check("st_busy",    32'(busy),    32'd1);
      check("st_isWrite", 32'(isWrite), 32'd0);
      if (k < 2) tick();
    end
    stall = 1'b0;
    tick();
    check("st_first_data",  32'(writeData), 32'h55);
    check("st_first_id",    32'(grantId),   32'd0);
    check("st_first_we",    32'(isWrite),   32'd1);
    tick();
    check("st_second_data", 32'(writeData), 32'hAA);
    check("st_second_id",   32'(grantId),   32'd1);
    check("st_second_we",   32'(isWrite),   32'd1);
    tick();

    // Lone requester streaming four writes.
    a0 = 0;
    for (int e = 0; e < 5; e++) begin
      reqV0 = (a0 < 4);
      set_req(1'b0, '{rg: 3'd6, is_reg: 1'b1, data: 8'(a0 + 1), wdata: 1'b1, default: '0});
      #1;
      if (reqV0) check("str_ready0", 32'(ready0), 32'd1);
      acc0 = reqV0 && ready0;
      tick();
      if (acc0) a0++;
      if (e >= 1) begin
        check("str_isWrite", 32'(isWrite),   32'd1);
        check("str_data",    32'(writeData), 32'(e));
      end
    end
    reqV0 = 1'b0;

    // Reset while both slots are full.
    stall = 1'b1;
    set_req(1'b0, '{rg: 3'd1, is_reg: 1'b1, data: 8'h77, wdata: 1'b1, default: '0});
    set_req(1'b1, '{rg: 3'd2, is_reg: 1'b1, data: 8'h88, wdata: 1'b1, default: '0});
    reqV0 = 1'b1;
    reqV1 = 1'b1;
    tick();
    reqV0 = 1'b0;
    reqV1 = 1'b0;
    check("mr_busy_before", 32'(busy),      32'd1);
    check("mr_data_held",   32'(writeData), 32'h04);
    RST_N = 1'b0;
    #1;
    check("mr_isWrite",   32'(isWrite),   32'd0);
    check("mr_writeData", 32'(writeData), 32'd0);
    check("mr_grantId",   32'(grantId),   32'd0);
    check("mr_busy",      32'(busy),      32'd0);
    check("mr_ready0",    32'(ready0),    32'd1);
    repeat (2) @(posedge CLK);
    #2;
    RST_N = 1'b1;
    stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("mr_no_write", 32'(isWrite), 32'd0);
      check("mr_no_busy",  32'(busy),    32'd0);
    end

    // Randomized phase: requesters hold an unaccepted offer stable.
    pend0 = 1'b0;
    pend1 = 1'b0;
    for (int n = 0; n < 400; n++) begin
      stall = ($urandom_range(0, 4) == 0);
      if (!pend0) begin
        reqV0 = ($urandom_range(0, 2) != 0);
        set_req(1'b0, rand_req());
      end
      if (!pend1) begin
        reqV1 = ($urandom_range(0, 2) != 0);
        set_req(1'b1, rand_req());
      end
      #1;
      pend0 = reqV0 && !ready0;
      pend1 = reqV1 && !ready1;
      tick();
    end
    reqV0 = 1'b0;
    reqV1 = 1'b0;
    stall = 1'b0;
    repeat (4) tick();

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regs_write_arbiter.md
# regs_write_arbiter

Two-requester arbiter that shares the single write port of the 8-bit register file (accumulators, general registers, flip and flag bits) between the core writeback stage (requester 0) and the debug/loader port (requester 1). Each requester has a one-entry holding slot with a valid/ready handshake. A round-robin grant drives a registered write bundle straight into the register file's write inputs. A stall input freezes granting without losing held requests.

## Interface
Parameters:
- DW, 8, data width of a register-file write
- AW, 3, register index width

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RST_N  input  1  asynchronous, active-low reset
- stall  input  1  when high, no grant is issued this cycle
- reqV0, reqV1  input  1 each  requester has a write to offer
- reqReg0, reqReg1  input  AW each  target register index
- reqIsReg0, reqIsReg1  input  1 each  1 = general register, 0 = accumulator
- reqData0, reqData1  input  DW each  write data
- reqWData0, reqWData1  input  1 each  1 = perform the data write
- reqFlipEn0, reqFlipEn1, reqFlip0, reqFlip1  input  1 each  flip-bit write enable and value
- reqFlagEn0, reqFlagEn1, reqFlag0, reqFlag1  input  1 each  flag-bit write enable and value
- ready0, ready1  output  1 each  slot can accept this cycle
- isWrite  output  1  register-file data write enable (registered)
- writeReg  output  AW  registered write index
- isRegW  output  1  registered register/accumulator select
- writeData  output  DW  registered write data
- writeFlip, flipin  output  1 each  registered flip-bit enable and value
- writeFlag, flagin  output  1 each  registered flag-bit enable and value
- grantId  output  1  requester whose bundle is on the outputs; valid when any enable is high
- busy  output  1  either slot full

## Operation
- Slot i holds one full request: reg, isReg, data, wdata, flipEn, flip, flagEn, flag. It also has a full bit, full_i.
- Eligible set E = {i : full_i}. If stall=1 or E is empty, there is no grant.
- Round-robin uses a 1-bit pointer `last` holding the most recently granted requester.
  - If E = {i}, grant i.
  - If E = {0,1}, grant the requester that is not `last`.
  - `last` updates only on a grant.
- ready_i = !full_i || (grant to i this cycle). This is combinational from state and stall, not from reqV.
- Accept rule: on a rising edge with reqV_i && ready_i, the slot loads the request and full_i becomes 1.
- Grant rule: on a rising edge with a grant to i:
  - Output registers load from slot i; grantId = i.
  - isWrite = wdata, writeFlip = flipEn, writeFlag = flagEn.
  - full_i clears unless it is refilled by a simultaneous accept.
- No grant on an edge: isWrite, writeFlip and writeFlag load 0. writeReg, isRegW, writeData, flipin, flagin and grantId hold their previous values.
- Requests to the same register from both requesters are never merged. Both are written in grant order, and the later write wins in the register file.
- A request with all three enables low is still accepted and granted. It produces a cycle with no enables asserted.
- busy = full_0 || full_1.

## Timing
- Reset (RST_N low, asynchronous):
  - full_0 = full_1 = 0 and last = 1, so requester 0 wins the first tie.
  - isWrite, writeFlip, writeFlag, writeReg, isRegW, writeData, flipin, flagin and grantId are all 0.
  - busy = 0. ready0 = ready1 = 1 while reset is deasserted and the slots are empty.
- Reset asserted mid-operation discards held requests with no write issued. Outputs drop to reset values immediately.
- Latency: a request accepted at edge N is granted at the earliest at edge N+1. Its enables are high during cycle N+1..N+2, and the register file commits it at edge N+2.
- Throughput: one grant per cycle. A lone requester holding reqV high sustains one write per cycle because refill and grant happen on the same edge.
- Contention: both requesters continuously valid gives strictly alternating grants, 0,1,0,1… after reset.
- Stall: while stall=1 nothing drains. ready_i = !full_i, and full slots and `last` are unchanged.
  - Output enables are 0 the cycle after a stalled edge.
  - On release, the held slots arbitrate normally.
- reqV_i is sampled only at rising edges. A request not accepted (ready_i=0) must be held stable by the requester.

## Test plan
- Reset, then reqV0=1 for one cycle with reqReg0=3'b010, reqIsReg0=1, reqData0=8'hA5, reqWData0=1:
  - Edge+1: isWrite=1, writeReg=2, isRegW=1, writeData=8'hA5, grantId=0.
  - Edge+2: isWrite=0, busy=0.
- Both reqV0/reqV1 held high for 6 cycles from reset, with distinct data 8'h10+n and 8'h20+n:
  - grantId sequence 0,1,0,1,0,1, with no request lost or duplicated.
  - The slot not granted on an edge shows ready=0 and keeps its pending data.
- Flip/flag path: reqV1 with reqWData1=0, reqFlipEn1=1, reqFlip1=1, reqFlagEn1=1, reqFlag1=0:
  - Output cycle has isWrite=0, writeFlip=1, flipin=1, writeFlag=1, flagin=0, grantId=1.
- stall=1 for 3 cycles while both slots fill with 8'h55 (req0) and 8'hAA (req1):
  - Enables stay 0, ready0=ready1=0, busy=1.
  - After stall drops: 8'h55 first, then 8'hAA on consecutive cycles.
- Single requester streaming 4 back-to-back writes (8'h01..8'h04):
  - ready0 stays 1 throughout and isWrite is high 4 consecutive cycles with data in order.
- RST_N pulsed low while both slots are full:
  - Outputs go to 0 immediately and busy=0.
  - No write appears after reset release until new requests are presented.
